sar_search: RTL and testbench

Successive-approximation search controller that drives a trial operand into an external magnitude comparator and uses its less/equal/greater flags to recover an unknown operand A, MSB first. It is the consumer side of the team's magnitude comparators: the comparator turns two values into a relation, and this block turns a sequence of relations back into a value. It sits next to a combinational comparator; A is connected to the comparator's A side and `trial` to its B side.

---
 rtl/sar_pkg.sv | 17 +
 rtl/sar_search.sv | 129 ++++++++++++
 tb/tb_sar_search.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the successive-approximation search
// controller. The state enum is used by the RTL. onehot3() classifies
// comparator flags and is shared by the RTL and the bench.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when exactly one of the three comparator flags is set.
  function automatic logic onehot3(input logic lt, input logic eq, input logic gt);
    return (lt ^ eq ^ gt) & ~(lt & eq & gt);
  endfunction

endpackage

// File: rtl/sar_search.sv
// sar_search: recovers an unknown operand A, MSB first, by driving trial
// values into an external combinational magnitude comparator and reading
// back its lt/eq/gt relation.
//
// Ports:
//   clk, rst         clock (rising edge), async active-high reset
//   start            search request, only honoured in IDLE
//   cmp_lt/eq/gt     comparator relation of A versus trial
//   trial [W-1:0]    registered trial value for the comparator's B side
//   busy             high during TEST cycles
//   done             one-cycle pulse; result/found/err are valid with it
//   result [W-1:0]   recovered A, held until the next accepted start
//   found            search exited on an exact-equal hit
//   err              comparator flags were not one-hot
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_n;  // accumulator after this cycle's keep/drop

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    acc_d     = acc_q;
    trial_d   = trial_q;
    result_d  = result_q;
    found_d   = found_q;
    err_d     = err_q;
    acc_n     = cmp_gt ? trial_q : acc_q;

    case (state_q)
      IDLE: begin
        trial_d = '0;
        if (start) begin
          state_d   = TEST;
          bit_idx_d = BW'(WIDTH - 1);
          acc_d     = '0;
          trial_d   = WIDTH'(1) << (WIDTH - 1);
          result_d  = '0;
          found_d   = 1'b0;
          err_d     = 1'b0;
        end
      end

      TEST: begin
        if (!onehot3(cmp_lt, cmp_eq, cmp_gt)) begin
          err_d    = 1'b1;
          result_d = '0;
          found_d  = 1'b0;
          state_d  = DONE;
        end else if (cmp_eq) begin
          // Exact hit: the remaining low bits of A are all zero.
          result_d = trial_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else if (bit_idx_q == '0) begin
          // Only A == 0 reaches here (every other value hits eq first).
          acc_d    = acc_n;
          result_d = acc_n;
          found_d  = 1'b0;
          state_d  = DONE;
        end else begin
          acc_d     = acc_n;
          bit_idx_d = bit_idx_q - BW'(1);
          trial_d   = acc_n | (WIDTH'(1) << (bit_idx_q - BW'(1)));
        end
      end

      DONE: begin
        trial_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      acc_q     <= '0;
      trial_q   <= '0;
      result_q  <= '0;
      found_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      acc_q     <= acc_d;
      trial_q   <= trial_d;
      result_q  <= result_d;
      found_q   <= found_d;
      err_q     <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q == TEST);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: drives a WIDTH=2 and a WIDTH=4 sar_search, each against a
// behavioural comparator on a bench-held operand A. Expected trial
// sequences, TEST lengths and results are computed arithmetically from A.
module tb_sar_search;
  import sar_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       st2 = 1'b0, st4 = 1'b0;
  logic [1:0] a2 = '0;
  logic [3:0] a4 = '0;
  logic       inj = 1'b0, inj_lt = 1'b0, inj_eq = 1'b0, inj_gt = 1'b0;

  logic [1:0] trial2, result2;
  logic       busy2, done2, found2, err2;
  logic [3:0] trial4, result4;
  logic       busy4, done4, found4, err4;

  logic lt2, eq2, gt2, lt4, eq4, gt4;
  assign lt2 = a2 < trial2;
  assign eq2 = a2 == trial2;
  assign gt2 = a2 > trial2;
  assign lt4 = inj ? inj_lt : (a4 < trial4);
  assign eq4 = inj ? inj_eq : (a4 == trial4);
  assign gt4 = inj ? inj_gt : (a4 > trial4);

  sar_search #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(st2),
    .cmp_lt(lt2), .cmp_eq(eq2), .cmp_gt(gt2),
    .trial(trial2), .busy(busy2), .done(done2),
    .result(result2), .found(found2), .err(err2)
  );

  sar_search #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(st4),
    .cmp_lt(lt4), .cmp_eq(eq4), .cmp_gt(gt4),
    .trial(trial4), .busy(busy4), .done(done4),
    .result(result4), .found(found4), .err(err4)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on A ----
  // TEST length: WIDTH minus position of lowest set bit; WIDTH for A==0.
  function automatic int exp_cycles(input int w, input int a);
    int p;
    if (a == 0) return w;
    p = 0;
    while (((a >> p) & 1) == 0) p++;
    return w - p;
  endfunction

  // k-th trial: A's bits above position b kept, bit b set, lower bits zero.
  function automatic int exp_trial(input int w, input int a, input int k);
    int b;
    b = w - 1 - k;
    return ((a >> (b + 1)) << (b + 1)) | (1 << b);
  endfunction

  // ---- per-instance views ----
  function automatic int o_trial(input int w);  return (w == 2) ? int'(trial2)  : int'(trial4);  endfunction
  function automatic int o_busy(input int w);   return (w == 2) ? int'(busy2)   : int'(busy4);   endfunction
  function automatic int o_done(input int w);   return (w == 2) ? int'(done2)   : int'(done4);   endfunction
  function automatic int o_result(input int w); return (w == 2) ? int'(result2) : int'(result4); endfunction
  function automatic int o_found(input int w);  return (w == 2) ? int'(found2)  : int'(found4);  endfunction
  function automatic int o_err(input int w);    return (w == 2) ? int'(err2)    : int'(err4);    endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 2) st2 = v; else st4 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full search with per-cycle trial/busy checks and done timing.
  task automatic search(input int w, input int a);
    int    n;
    string id;
    n  = exp_cycles(w, a);
    id = $sformatf("w%0d_a%0d", w, a);
    if (w == 2) a2 = 2'(a); else a4 = 4'(a);
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    for (int k = 0; k < n; k++) begin
      chk({id, "_busy"}, o_busy(w), 1);
      chk({id, "_done_early"}, o_done(w), 0);
      chk($sformatf("%s_trial%0d", id, k), o_trial(w), exp_trial(w, a, k));
      tick();
    end
    chk({id, "_done"}, o_done(w), 1);
    chk({id, "_busy_off"}, o_busy(w), 0);
    chk({id, "_result"}, o_result(w), a);
    chk({id, "_found"}, o_found(w), (a != 0) ? 1 : 0);
    chk({id, "_err"}, o_err(w), 0);
    tick();
    chk({id, "_done_pulse"}, o_done(w), 0);
    chk({id, "_result_hold"}, o_result(w), a);
    chk({id, "_idle_trial"}, o_trial(w), 0);
  endtask

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_trial4", trial4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_result4", result4, 0);
    chk("rst_found4", found4, 0);
    chk("rst_err4", err4, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_result2", result2, 0);
    rst = 1'b0;
    tick();

    // ---- WIDTH=2 sweep ----
    for (int a = 0; a < 4; a++) search(2, a);
    search(2, 3);

    // ---- WIDTH=4 directed ----
    search(4, 8);
    search(4, 5);
    search(4, 0);
    search(4, 15);

    // ---- randomized ----
    for (int i = 0; i < 25; i++) search(4, int'($urandom_range(0, 15)));
    for (int i = 0; i < 8; i++)  search(2, int'($urandom_range(0, 3)));

    // ---- non-one-hot flags: lt+gt, then none ----
    for (int p = 0; p < 2; p++) begin
      search(4, 5);
      inj    = 1'b1;
      inj_lt = (p == 0);
      inj_eq = 1'b0;
      inj_gt = (p == 0);
      set_start(4, 1'b1);
      tick();
      set_start(4, 1'b0);
      chk("inj_busy", busy4, 1);
      tick();
      chk("inj_done", done4, 1);
      chk("inj_err", err4, onehot3(inj_lt, inj_eq, inj_gt) ? 0 : 1);
      chk("inj_result", result4, 0);
      chk("inj_found", found4, 0);
      inj = 1'b0;
      tick();
      chk("inj_done_pulse", done4, 0);
      chk("inj_err_hold", err4, 1);
      search(4, 6);  // clean search must clear err
    end

    // ---- start held high: 4 TEST, 1 DONE, 1 IDLE, repeat ----
    a4 = 4'd9;
    st4 = 1'b1;
    tick();
    for (int c = 0; c < 24; c++) begin
      int ph;
      ph = c % 6;
      chk($sformatf("hold_busy_c%0d", c), busy4, (c < 18 && ph < 4) ? 1 : 0);
      chk($sformatf("hold_done_c%0d", c), done4, (c < 18 && ph == 4) ? 1 : 0);
      if (c < 18 && ph == 4) chk("hold_result", result4, 9);
      if (c == 17) st4 = 1'b0;
      tick();
    end

    // ---- async reset in 2nd TEST cycle ----
    search(4, 12);
    a4 = 4'd1;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    tick();
    chk("mid_busy_pre", busy4, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", busy4, 0);
    chk("mid_trial", trial4, 0);
    chk("mid_done", done4, 0);
    chk("mid_result", result4, 0);
    chk("mid_found", found4, 0);
    chk("mid_err", err4, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("post_rst_done", done4, 0);
      chk("post_rst_busy", busy4, 0);
      tick();
    end
    search(4, 1);
    search(4, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
